param_cache_memory: RTL

//   Parametrised successor to the processor memory module: a direct-mapped, write-back cache in

---
 rtl/mem_pkg.sv | 34 +++
 rtl/backing_ram.sv | 75 +++++++
 rtl/param_cache_memory.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM state type, cntrl opcodes and clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EVICT  = 3'd2,
        ST_FILL   = 3'd3,
        ST_PTR    = 3'd4,
        ST_DONE   = 3'd5,
        ST_FLUSH  = 3'd6
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_WR    = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backing_ram.sv
`default_nettype none
// ============================================================================
// Module      : backing_ram
// Description : 2**AW x DW word RAM behind a RAM_LAT-cycle req/ack pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module backing_ram #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RAM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wData,
    output logic          o_ack,
    output logic [DW-1:0] o_rData
);

    logic [DW-1:0] r_mem [2**AW];
    logic          w_ackWe;
    logic [AW-1:0] w_ackAddr;
    logic [DW-1:0] w_ackData;

    generate
        if (RAM_LAT == 1) begin : g_lat1
            assign o_ack     = i_req;
            assign w_ackWe   = i_we;
            assign w_ackAddr = i_addr;
            assign w_ackData = i_wData;
        end else begin : g_latN
            localparam int DEPTH = RAM_LAT - 1;
            logic          r_pValid [DEPTH];
            logic          r_pWe    [DEPTH];
            logic [AW-1:0] r_pAddr  [DEPTH];
            logic [DW-1:0] r_pData  [DEPTH];

            // Only the valid bits are reset, so an abandoned request never acks.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_pValid[i] <= 1'b0;
                end else begin
                    r_pValid[0] <= i_req;
                    for (int i = 1; i < DEPTH; i++) r_pValid[i] <= r_pValid[i-1];
                end
            end

            always_ff @(posedge clk) begin
                r_pWe[0]   <= i_we;
                r_pAddr[0] <= i_addr;
                r_pData[0] <= i_wData;
                for (int i = 1; i < DEPTH; i++) begin
                    r_pWe[i]   <= r_pWe[i-1];
                    r_pAddr[i] <= r_pAddr[i-1];
                    r_pData[i] <= r_pData[i-1];
                end
            end

            assign o_ack     = r_pValid[DEPTH-1];
            assign w_ackWe   = r_pWe[DEPTH-1];
            assign w_ackAddr = r_pAddr[DEPTH-1];
            assign w_ackData = r_pData[DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (o_ack && w_ackWe) r_mem[w_ackAddr] <= w_ackData;
    end

    assign o_rData = r_mem[w_ackAddr];

endmodule
`default_nettype wire

// File: rtl/param_cache_memory.sv
`default_nettype none
// ============================================================================
// Module      : param_cache_memory
// Description : Direct-mapped write-back cache over backing_ram with indirect
//               (pointer) access and full flush.
// Revision    : 1.0 - initial release
// ============================================================================
module param_cache_memory
    import mem_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int LINES   = 16,
    parameter int RAM_LAT = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [1:0]    cntrl,
    input  logic          isIndirect,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dataIn,
    output logic [DW-1:0] dataOut,
    output logic          dataReady,
    output logic          busy,
    output logic [1:0]    hitClean
);

    localparam int IW = clog2(LINES);
    localparam int TW = (AW > IW) ? AW - IW : 1;

    state_t           r_state, w_nextState;
    logic [1:0]       r_op;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_dataIn;
    logic             r_indirect, r_wait;
    logic [IW-1:0]    r_flushIdx;
    logic [LINES-1:0] r_valid, r_dirty;
    logic [TW-1:0]    r_tagArr  [LINES];
    logic [DW-1:0]    r_dataArr [LINES];
    logic [DW-1:0]    r_dataOut;
    logic [1:0]       r_hitClean;

    logic [IW-1:0]    w_idx;
    logic [TW-1:0]    w_tag;
    logic             w_lineHit, w_needEvict, w_flushDirty;
    logic [DW-1:0]    w_word;
    logic [AW-1:0]    w_ptrAddr;
    logic             w_ramReq, w_ramWe, w_ramAck;
    logic [AW-1:0]    w_ramAddr;
    logic [DW-1:0]    w_ramWData, w_ramRData;
    logic             w_accept, w_resolve, w_install, w_flushClean, w_flushStep;

    assign w_idx        = r_addr[IW-1:0];
    assign w_tag        = TW'(r_addr >> IW);
    assign w_lineHit    = r_valid[w_idx] && (r_tagArr[w_idx] == w_tag);
    assign w_needEvict  = r_valid[w_idx] && r_dirty[w_idx] && !w_lineHit;
    assign w_flushDirty = r_valid[r_flushIdx] && r_dirty[r_flushIdx];
    assign w_word       = (r_state == ST_FILL) ? w_ramRData : r_dataArr[w_idx];

    generate
        if (DW >= AW) begin : g_ptrTrunc
            assign w_ptrAddr = w_word[AW-1:0];
        end else begin : g_ptrZext
            assign w_ptrAddr = {{(AW-DW){1'b0}}, w_word};
        end
    endgenerate

    backing_ram #(.AW(AW), .DW(DW), .RAM_LAT(RAM_LAT)) u_ram (
        .clk     (clk),
        .rst     (clr),
        .i_req   (w_ramReq),
        .i_we    (w_ramWe),
        .i_addr  (w_ramAddr),
        .i_wData (w_ramWData),
        .o_ack   (w_ramAck),
        .o_rData (w_ramRData)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // The pointer redirect happens in the cycle the pointer word resolves
    // (lookup hit or fill ack), so ST_PTR is never occupied.
    always_comb begin
        w_nextState  = r_state;
        w_ramReq     = 1'b0;
        w_ramWe      = 1'b0;
        w_ramAddr    = r_addr;
        w_ramWData   = r_dataArr[w_idx];
        w_accept     = 1'b0;
        w_resolve    = 1'b0;
        w_install    = 1'b0;
        w_flushClean = 1'b0;
        w_flushStep  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (cntrl != OP_NOP)) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (r_op == OP_FLUSH) begin
                    w_nextState = ST_FLUSH;
                end else if (w_lineHit) begin
                    w_resolve   = 1'b1;
                    w_nextState = r_indirect ? ST_LOOKUP : ST_DONE;
                end else begin
                    w_nextState = w_needEvict ? ST_EVICT : ST_FILL;
                end
            end
            ST_EVICT: begin
                w_ramReq  = !r_wait;
                w_ramWe   = 1'b1;
                w_ramAddr = AW'({r_tagArr[w_idx], w_idx});
                if (w_ramAck) w_nextState = ST_FILL;
            end
            ST_FILL: begin
                w_ramReq = !r_wait;
                if (w_ramAck) begin
                    w_install   = 1'b1;
                    w_resolve   = 1'b1;
                    w_nextState = r_indirect ? ST_LOOKUP : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (w_flushDirty) begin
                    w_ramReq   = !r_wait;
                    w_ramWe    = 1'b1;
                    w_ramAddr  = AW'({r_tagArr[r_flushIdx], r_flushIdx});
                    w_ramWData = r_dataArr[r_flushIdx];
                    if (w_ramAck) begin
                        w_flushClean = 1'b1;
                        w_flushStep  = 1'b1;
                    end
                end else begin
                    w_flushStep = 1'b1;
                end
                if (w_flushStep && (r_flushIdx == IW'(LINES - 1))) w_nextState = ST_DONE;
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op       <= OP_NOP;
            r_addr     <= '0;
            r_dataIn   <= '0;
            r_indirect <= 1'b0;
            r_wait     <= 1'b0;
            r_flushIdx <= '0;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_dataOut  <= '0;
            r_hitClean <= 2'b00;
        end else begin
            if (w_ramAck)      r_wait <= 1'b0;
            else if (w_ramReq) r_wait <= 1'b1;
            if (w_accept) begin
                r_op       <= cntrl;
                r_addr     <= addr;
                r_dataIn   <= dataIn;
                r_indirect <= isIndirect && (cntrl != OP_FLUSH);
                r_flushIdx <= '0;
            end
            if ((r_state == ST_LOOKUP) && (r_op != OP_FLUSH) && !r_indirect)
                r_hitClean <= {w_lineHit, !w_needEvict};
            if (w_install) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
            if (w_resolve) begin
                if (r_indirect) begin
                    r_addr     <= w_ptrAddr;
                    r_indirect <= 1'b0;
                end else if (r_op == OP_RD) begin
                    r_dataOut <= w_word;
                end else begin
                    r_dirty[w_idx] <= 1'b1;
                end
            end
            if (w_flushClean) r_dirty[r_flushIdx] <= 1'b0;
            if (w_flushStep)  r_flushIdx <= r_flushIdx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_install) begin
            r_tagArr[w_idx]  <= w_tag;
            r_dataArr[w_idx] <= w_ramRData;
        end
        if (w_resolve && !r_indirect && (r_op == OP_WR)) r_dataArr[w_idx] <= r_dataIn;
    end

    assign dataOut   = r_dataOut;
    assign dataReady = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign hitClean  = r_hitClean;

endmodule
`default_nettype wire
